// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: RV32I control decode carried through ID/EX, EX/MEM and MEM/WB with load-use stall and flush
module rv_pipe_ctrl #(
    parameter int ALUOP_W    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_a_sel,
    output logic                  ex_branch,
    output logic [1:0]            ex_jump,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_sel,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  illegal,
    output logic [ILL_CNT_W-1:0]  ill_count
);
    // d = {alu_op[1:0], alu_src, a_sel[1:0], mem_read, mem_write, reg_write, wb_sel[1:0], branch, jump[1:0]}
    logic [12:0] d, dk;
    logic legal, u1, u2, take, acc;
    logic ex_mr, ex_mw, ex_rw, mem_rw;
    logic [1:0] ex_wb_sel, mem_wb_sel;
    always_comb begin
        d = '0;
        legal = 1'b1;
        u1 = 1'b1;
        u2 = 1'b0;
        case (id_opcode)
            7'b0000011: d = 13'b01_1_00_1_0_1_01_0_00;
            7'b0100011: begin d = 13'b01_1_00_0_1_0_00_0_00; u2 = 1'b1; end
            7'b0110011: begin d = 13'b10_0_00_0_0_1_00_0_00; u2 = 1'b1; end
            7'b1100011: begin d = 13'b11_0_00_0_0_0_00_1_00; u2 = 1'b1; end
            7'b0010011: d = 13'b00_1_00_0_0_1_00_0_00;
            7'b0110111: begin d = 13'b01_1_01_0_0_1_00_0_00; u1 = 1'b0; end
            7'b0010111: begin d = 13'b01_1_10_0_0_1_00_0_00; u1 = 1'b0; end
            7'b1101111: begin d = 13'b01_1_10_0_0_1_10_0_01; u1 = 1'b0; end
            7'b1100111: d = 13'b01_1_00_0_0_1_10_0_10;
            default: begin legal = 1'b0; u1 = 1'b0; end
        endcase
    end
    assign stall = id_valid & ~flush & ex_valid & ex_mr & (ex_rd != '0) &
                   ((u1 & (ex_rd == id_rs1)) | (u2 & (ex_rd == id_rs2)));
    assign take  = id_valid & ~flush & ~stall & legal;
    assign acc   = id_valid & ~flush & ~legal;
    assign dk    = take ? d : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_a_sel     <= '0;
            ex_mr        <= 1'b0;
            ex_mw        <= 1'b0;
            ex_rw        <= 1'b0;
            ex_wb_sel    <= '0;
            ex_branch    <= 1'b0;
            ex_jump      <= '0;
            ex_rd        <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_rw       <= 1'b0;
            mem_wb_sel   <= '0;
            mem_rd       <= '0;
            wb_reg_write <= 1'b0;
            wb_sel       <= '0;
            wb_rd        <= '0;
            illegal      <= 1'b0;
            ill_count    <= '0;
        end else begin
            ex_valid     <= take;
            ex_alu_op    <= ALUOP_W'(dk[12:11]);
            ex_alu_src   <= dk[10];
            ex_a_sel     <= dk[9:8];
            ex_mr        <= dk[7];
            ex_mw        <= dk[6];
            ex_rw        <= dk[5] & (id_rd != '0);
            ex_wb_sel    <= dk[4:3];
            ex_branch    <= dk[2];
            ex_jump      <= dk[1:0];
            ex_rd        <= take ? id_rd : '0;
            mem_read     <= ex_mr;
            mem_write    <= ex_mw;
            mem_rw       <= ex_rw;
            mem_wb_sel   <= ex_wb_sel;
            mem_rd       <= ex_rd;
            wb_reg_write <= mem_rw;
            wb_sel       <= mem_wb_sel;
            wb_rd        <= mem_rd;
            illegal      <= acc;
            ill_count    <= (acc && !(&ill_count)) ? ill_count + 1'b1 : ill_count;
        end
    end
endmodule
